// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the tartaruga core pipeline.
// Holds the issue-stage stall reasons and the per-slot completion record.
package tartaruga_pkg;

    localparam int unsigned MAX_EXE_STAGES = 4;
    localparam int unsigned EXE_NUM_STAGES = MAX_EXE_STAGES;
    localparam int unsigned EXE_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        RAW    = 2'd1,
        WAW    = 2'd2,
        STRUCT = 2'd3
    } stall_cause_t;

    typedef struct packed {
        logic                      valid;
        logic                      we;
        logic [EXE_REG_ADDR_W-1:0] rd;
    } exe_slot_t;

endpackage

// File: rtl/exe_issue_ctrl_if.sv
// Decode-to-issue handshake: decode (master) offers an op, the issue
// controller (slave) answers with a combinational grant and stall reason.
interface exe_issue_ctrl_if #(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned REG_ADDR_W = 5
);
    import tartaruga_pkg::*;

    localparam int unsigned LAT_W = $clog2(NUM_STAGES + 1);

    logic                  issue_valid_i;
    logic [LAT_W-1:0]      issue_latency_i;
    logic                  issue_rd_we_i;
    logic [REG_ADDR_W-1:0] issue_rd_i;
    logic                  issue_use_rs1_i;
    logic [REG_ADDR_W-1:0] issue_rs1_i;
    logic                  issue_use_rs2_i;
    logic [REG_ADDR_W-1:0] issue_rs2_i;
    logic                  issue_grant_o;
    stall_cause_t          stall_cause_o;

    modport master (
        output issue_valid_i, issue_latency_i, issue_rd_we_i, issue_rd_i,
               issue_use_rs1_i, issue_rs1_i, issue_use_rs2_i, issue_rs2_i,
        input  issue_grant_o, stall_cause_o
    );

    modport slave (
        input  issue_valid_i, issue_latency_i, issue_rd_we_i, issue_rd_i,
               issue_use_rs1_i, issue_rs1_i, issue_use_rs2_i, issue_rs2_i,
        output issue_grant_o, stall_cause_o
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: adds one per cycle while inc_i is high, holds at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/exe_issue_ctrl.sv
// Issue scheduler: tracks in-flight ops by completion slot and grants issue only when
// the writeback port is free, no source is pending and no out-of-order WAW would occur.
module exe_issue_ctrl
    import tartaruga_pkg::*;
#(
    parameter int unsigned  NUM_STAGES = EXE_NUM_STAGES,
    parameter int unsigned  REG_ADDR_W = EXE_REG_ADDR_W,
    parameter int unsigned  CNT_W      = 32,
    localparam int unsigned LAT_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    exe_issue_ctrl_if.slave       issue_if,
    input  logic                  flush_i,
    output logic                  wb_valid_o,
    output logic                  wb_rd_we_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic [LAT_W-1:0]      occupancy_o,
    output logic [CNT_W-1:0]      raw_stall_cnt_o,
    output logic [CNT_W-1:0]      waw_stall_cnt_o,
    output logic [CNT_W-1:0]      struct_stall_cnt_o
);

    if (REG_ADDR_W != EXE_REG_ADDR_W) begin : g_bad_rd_width
        $error("exe_issue_ctrl: REG_ADDR_W must match EXE_REG_ADDR_W");
    end

    exe_slot_t [NUM_STAGES-1:0] slot_q, slot_d;
    logic [LAT_W-1:0]           occ_q, occ_d;

    int unsigned  lat;
    logic         lat_legal;
    logic         raw_hz, waw_hz, struct_hz;
    stall_cause_t cause;
    logic         grant;

    // Hazard detection; slot 0 still counts for RAW since there is no bypass.
    always_comb begin
        lat       = 32'(issue_if.issue_latency_i);
        lat_legal = (lat != 0) && (lat <= NUM_STAGES);
        raw_hz    = 1'b0;
        waw_hz    = 1'b0;
        struct_hz = 1'b0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (slot_q[i].valid && slot_q[i].we && (slot_q[i].rd != '0)) begin
                if ((issue_if.issue_use_rs1_i && (issue_if.issue_rs1_i == slot_q[i].rd)) ||
                    (issue_if.issue_use_rs2_i && (issue_if.issue_rs2_i == slot_q[i].rd))) begin
                    raw_hz = 1'b1;
                end
                if (issue_if.issue_rd_we_i && (i >= lat) &&
                    (issue_if.issue_rd_i == slot_q[i].rd)) begin
                    waw_hz = 1'b1;
                end
            end
            // Slot L shifts into L-1 on the same edge the new op would land there.
            if ((i == lat) && slot_q[i].valid) begin
                struct_hz = 1'b1;
            end
        end

        cause = NONE;
        if (issue_if.issue_valid_i && !flush_i) begin
            if (!lat_legal) begin
                cause = STRUCT;
            end else if (raw_hz) begin
                cause = RAW;
            end else if (waw_hz) begin
                cause = WAW;
            end else if (struct_hz) begin
                cause = STRUCT;
            end
        end
        grant = issue_if.issue_valid_i && !flush_i && (cause == NONE);
    end

    always_comb begin
        slot_d[NUM_STAGES-1] = '0;
        for (int unsigned i = 0; i + 1 < NUM_STAGES; i++) begin
            slot_d[i] = slot_q[i+1];
        end
        if (grant) begin
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                if (i + 1 == lat) begin
                    slot_d[i] = '{valid: 1'b1,
                                  we:    issue_if.issue_rd_we_i,
                                  rd:    issue_if.issue_rd_i};
                end
            end
        end
        occ_d = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            occ_d = occ_d + LAT_W'(slot_d[i].valid);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            slot_q <= '0;
            occ_q  <= '0;
        end else begin
            slot_q <= slot_d;
            occ_q  <= occ_d;
        end
    end

    assign issue_if.issue_grant_o = grant;
    assign issue_if.stall_cause_o = cause;
    assign wb_valid_o             = slot_q[0].valid;
    assign wb_rd_we_o             = slot_q[0].we;
    assign wb_rd_o                = slot_q[0].rd;
    assign occupancy_o            = occ_q;

    sat_counter #(.WIDTH(CNT_W)) u_raw_cnt (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .inc_i   (cause == RAW),
        .count_o (raw_stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_waw_cnt (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .inc_i   (cause == WAW),
        .count_o (waw_stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_struct_cnt (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .inc_i   (cause == STRUCT),
        .count_o (struct_stall_cnt_o)
    );

    illegal_latency_a: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (issue_if.issue_valid_i && !flush_i) |-> lat_legal)
        else $error("exe_issue_ctrl: illegal issue latency %0d", issue_if.issue_latency_i);

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Self-checking bench for exe_issue_ctrl: scoreboarded writeback order/timing,
// directed hazard scenarios and a narrow-counter instance for saturation.
module tb_exe_issue_ctrl;
    import tartaruga_pkg::*;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        int unsigned due;
    } exp_wb_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        flush4;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [2:0]  occ;
    logic [31:0] raw_cnt, waw_cnt, struct_cnt;
    logic        wb4_valid, wb4_we;
    logic [4:0]  wb4_rd;
    logic [2:0]  occ4;
    logic [3:0]  raw4, waw4, struct4;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned exp_raw = 0, exp_waw = 0, exp_struct = 0;
    exp_wb_t     sb_q[$];

    exe_issue_ctrl_if #(.NUM_STAGES(4), .REG_ADDR_W(5)) dut_if ();
    exe_issue_ctrl_if #(.NUM_STAGES(4), .REG_ADDR_W(5)) dut4_if ();

    exe_issue_ctrl #(.NUM_STAGES(4), .REG_ADDR_W(5), .CNT_W(32)) u_dut (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .issue_if           (dut_if),
        .flush_i            (flush),
        .wb_valid_o         (wb_valid),
        .wb_rd_we_o         (wb_we),
        .wb_rd_o            (wb_rd),
        .occupancy_o        (occ),
        .raw_stall_cnt_o    (raw_cnt),
        .waw_stall_cnt_o    (waw_cnt),
        .struct_stall_cnt_o (struct_cnt)
    );

    exe_issue_ctrl #(.NUM_STAGES(4), .REG_ADDR_W(5), .CNT_W(4)) u_dut4 (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .issue_if           (dut4_if),
        .flush_i            (flush4),
        .wb_valid_o         (wb4_valid),
        .wb_rd_we_o         (wb4_we),
        .wb_rd_o            (wb4_rd),
        .occupancy_o        (occ4),
        .raw_stall_cnt_o    (raw4),
        .waw_stall_cnt_o    (waw4),
        .struct_stall_cnt_o (struct4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Writeback monitor: every pulse must match a scoreboard entry due this cycle.
    always @(negedge clk) begin : wb_mon
        int idx;
        if (rstn && wb_valid) begin
            idx = -1;
            foreach (sb_q[k]) if (sb_q[k].due == cyc) idx = k;
            check("wb_expected", 32'(idx >= 0), 32'd1);
            if (idx >= 0) begin
                check("wb_rd", 32'(wb_rd), 32'(sb_q[idx].rd));
                check("wb_we", 32'(wb_we), 32'(sb_q[idx].we));
                sb_q.delete(idx);
            end
        end
    end

    task automatic issue(input int unsigned l, input logic we, input logic [4:0] rd,
                         input logic u1, input logic [4:0] rs1,
                         input logic u2, input logic [4:0] rs2);
        dut_if.issue_valid_i   = 1'b1;
        dut_if.issue_latency_i = 3'(l);
        dut_if.issue_rd_we_i   = we;
        dut_if.issue_rd_i      = rd;
        dut_if.issue_use_rs1_i = u1;
        dut_if.issue_rs1_i     = rs1;
        dut_if.issue_use_rs2_i = u2;
        dut_if.issue_rs2_i     = rs2;
    endtask

    task automatic idle();
        issue(1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        dut_if.issue_valid_i = 1'b0;
    endtask

    // Check the combinational answer mid-cycle, then the counters after the edge.
    task automatic tick_chk(input logic eg, input stall_cause_t ec);
        @(negedge clk);
        check("grant", 32'(dut_if.issue_grant_o), 32'(eg));
        check("cause", 32'(dut_if.stall_cause_o), 32'(ec));
        if (eg) begin
            sb_q.push_back('{we: dut_if.issue_rd_we_i, rd: dut_if.issue_rd_i,
                             due: cyc + 32'(dut_if.issue_latency_i)});
        end
        case (ec)
            RAW:     exp_raw++;
            WAW:     exp_waw++;
            STRUCT:  exp_struct++;
            default: ;
        endcase
        @(posedge clk);
        #1;
        check("raw_cnt", raw_cnt, exp_raw);
        check("waw_cnt", waw_cnt, exp_waw);
        check("struct_cnt", struct_cnt, exp_struct);
    endtask

    task automatic idle_ticks(input int n);
        idle();
        repeat (n) tick_chk(1'b0, NONE);
    endtask

    initial begin
        rstn   = 1'b0;
        flush  = 1'b0;
        flush4 = 1'b0;
        idle();
        dut4_if.issue_valid_i   = 1'b0;
        dut4_if.issue_latency_i = 3'd4;
        dut4_if.issue_rd_we_i   = 1'b1;
        dut4_if.issue_rd_i      = 5'd3;
        dut4_if.issue_use_rs1_i = 1'b1;
        dut4_if.issue_rs1_i     = 5'd3;
        dut4_if.issue_use_rs2_i = 1'b0;
        dut4_if.issue_rs2_i     = 5'd0;

        #12;
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_we", 32'(wb_we), 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_occ", 32'(occ), 32'd0);
        check("rst_raw", raw_cnt, 32'd0);
        check("rst_struct", struct_cnt, 32'd0);
        check("rst_grant", 32'(dut_if.issue_grant_o), 32'd0);
        check("rst_cause", 32'(dut_if.stall_cause_o), 32'(NONE));
        @(posedge clk);
        #1 rstn = 1'b1;
        idle_ticks(2);

        // Single ALU op
        issue(1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        tick_chk(1'b1, NONE);
        check("occ_alu_1", 32'(occ), 32'd1);
        idle_ticks(1);
        check("occ_alu_0", 32'(occ), 32'd0);
        idle_ticks(2);

        // Writeback-port conflict
        issue(4, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        tick_chk(1'b1, NONE);
        idle_ticks(2);
        issue(1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
        tick_chk(1'b0, STRUCT);
        tick_chk(1'b1, NONE);
        idle_ticks(3);

        // RAW on a long-latency result, including its wb cycle
        issue(4, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        tick_chk(1'b1, NONE);
        issue(1, 1'b1, 5'd8, 1'b1, 5'd3, 1'b0, 5'd0);
        repeat (4) tick_chk(1'b0, RAW);
        tick_chk(1'b1, NONE);
        idle_ticks(3);

        // WAW: short op must not retire before the older long op
        issue(4, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
        tick_chk(1'b1, NONE);
        issue(1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
        repeat (3) tick_chk(1'b0, WAW);
        tick_chk(1'b1, NONE);
        idle_ticks(3);

        // x0 never hazards
        issue(3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick_chk(1'b1, NONE);
        issue(1, 1'b1, 5'd6, 1'b1, 5'd0, 1'b1, 5'd0);
        tick_chk(1'b1, NONE);
        idle_ticks(3);

        // Flush suppresses issue and counting but not in-flight wb
        issue(3, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0);
        tick_chk(1'b1, NONE);
        issue(1, 1'b1, 5'd11, 1'b1, 5'd10, 1'b0, 5'd0);
        flush = 1'b1;
        repeat (2) tick_chk(1'b0, NONE);
        flush = 1'b0;
        tick_chk(1'b0, RAW);
        tick_chk(1'b1, NONE);
        idle_ticks(3);

        // Reset with three ops in flight
        issue(4, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0);
        tick_chk(1'b1, NONE);
        issue(4, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0);
        tick_chk(1'b1, NONE);
        issue(4, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
        tick_chk(1'b1, NONE);
        idle_ticks(1);
        check("pre_rst_occ", 32'(occ), 32'd3);
        check("pre_rst_wb_valid", 32'(wb_valid), 32'd1);
        check("pre_rst_wb_rd", 32'(wb_rd), 32'd1);
        #3 rstn = 1'b0;
        #1;
        check("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
        check("mid_rst_wb_rd", 32'(wb_rd), 32'd0);
        check("mid_rst_occ", 32'(occ), 32'd0);
        check("mid_rst_raw", raw_cnt, 32'd0);
        check("mid_rst_waw", waw_cnt, 32'd0);
        check("mid_rst_struct", struct_cnt, 32'd0);
        sb_q.delete();
        exp_raw    = 0;
        exp_waw    = 0;
        exp_struct = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        idle_ticks(8);
        check("post_rst_occ", 32'(occ), 32'd0);

        // Narrow counter saturation: constant self-dependent request stalls 4 of every 5 cycles
        dut4_if.issue_valid_i = 1'b1;
        repeat (10) tick_chk(1'b0, NONE);
        check("sat_raw_mid", 32'(raw4), 32'd8);
        repeat (15) tick_chk(1'b0, NONE);
        check("sat_raw_max", 32'(raw4), 32'd15);
        dut4_if.issue_valid_i = 1'b0;
        idle_ticks(6);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
